// File: rtl/encoder_8_3_queue_pkg.sv
// Shared constants and helpers for the 8-to-3 event encoder and its companion decoder.
package encoder_8_3_queue_pkg;

    localparam int N_REQ  = 8;
    localparam int CODE_W = 3;

    // Default arbitration order: 1 = highest pending index wins.
    localparam bit HIGH_FIRST_DEF = 1'b1;

    typedef logic [N_REQ-1:0]  req_t;
    typedef logic [CODE_W-1:0] code_t;

    // One-hot select from a binary code; shared with the 3-to-8 decoder.
    function automatic req_t code_to_onehot(input code_t code);
        req_t one_s;
        one_s = {{(N_REQ-1){1'b0}}, 1'b1};
        return one_s << code;
    endfunction

endpackage

// File: rtl/encoder_8_3_queue_if.sv
// Request/code handshake bundle of the event encoder.
interface encoder_8_3_queue_if;
    import encoder_8_3_queue_pkg::*;

    logic  E;
    req_t  In;
    code_t Out;
    logic  Valid;
    logic  Ready;
    req_t  Pending;
    logic  Lost;

    // Encoder side: takes requests and Ready, presents codes.
    modport master (
        input  E,
        input  In,
        input  Ready,
        output Out,
        output Valid,
        output Pending,
        output Lost
    );

    // Requester/consumer side.
    modport slave (
        output E,
        output In,
        output Ready,
        input  Out,
        input  Valid,
        input  Pending,
        input  Lost
    );

endinterface

// File: rtl/encoder_8_3_queue_prio_enc_8_3.sv
// Combinational 8-to-3 priority encoder; direction chosen by HIGH_FIRST.
module prio_enc_8_3
    import encoder_8_3_queue_pkg::*;
#(
    parameter bit HIGH_FIRST = HIGH_FIRST_DEF
) (
    input  req_t  req,
    output code_t code,
    output logic  any
);

    // Scan so that the last hit in loop order is the winning index.
    always_comb begin
        code = {CODE_W{1'b0}};
        any  = 1'b0;
        if (HIGH_FIRST) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req[i]) begin
                    code = CODE_W'(i);
                    any  = 1'b1;
                end else begin
                    any  = any;
                end
            end
        end else begin
            for (int i = N_REQ - 1; i >= 0; i--) begin
                if (req[i]) begin
                    code = CODE_W'(i);
                    any  = 1'b1;
                end else begin
                    any  = any;
                end
            end
        end
    end

endmodule

// File: rtl/encoder_8_3_queue.sv
// Event encoder: queues request lines in a pending register and emits one
// 3-bit index per accepted valid/ready transfer, in priority order.
module encoder_8_3_queue
    import encoder_8_3_queue_pkg::*;
#(
    parameter bit HIGH_FIRST = HIGH_FIRST_DEF
) (
    input  logic clk,
    input  logic rst,
    encoder_8_3_queue_if.master bus
);

    req_t  pend_r;
    code_t out_r;
    logic  vld_r;
    logic  lost_r;

    code_t sel_s;
    logic  any_s;
    logic  load_s;
    req_t  clr_s;
    req_t  req_s;
    req_t  pend_nxt_s;
    logic  lost_nxt_s;

    // Selection looks only at registered pend; new requests never bypass it.
    prio_enc_8_3 #(.HIGH_FIRST(HIGH_FIRST)) u_prio (
        .req  (pend_r),
        .code (sel_s),
        .any  (any_s)
    );

    // Load/clear decision and next pending set; a re-request of the bit
    // being loaded survives as a fresh event because set is OR-ed last.
    always_comb begin
        load_s     = (!vld_r || bus.Ready) && any_s;
        clr_s      = {N_REQ{1'b0}};
        req_s      = {N_REQ{1'b0}};
        if (load_s) begin
            clr_s = code_to_onehot(sel_s);
        end else begin
            clr_s = {N_REQ{1'b0}};
        end
        if (bus.E) begin
            req_s = bus.In;
        end else begin
            req_s = {N_REQ{1'b0}};
        end
        pend_nxt_s = (pend_r & ~clr_s) | req_s;
        lost_nxt_s = |(req_s & pend_r & ~clr_s);
    end

    // Pending set, output stage and merge flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_r <= {N_REQ{1'b0}};
            out_r  <= {CODE_W{1'b0}};
            vld_r  <= 1'b0;
            lost_r <= 1'b0;
        end else begin
            pend_r <= pend_nxt_s;
            lost_r <= lost_nxt_s;
            if (load_s) begin
                out_r <= sel_s;
                vld_r <= 1'b1;
            end else if (vld_r && bus.Ready) begin
                vld_r <= 1'b0;
            end else begin
                vld_r <= vld_r;
            end
        end
    end

    assign bus.Out     = out_r;
    assign bus.Valid   = vld_r;
    assign bus.Pending = pend_r;
    assign bus.Lost    = lost_r;

endmodule

// File: tb/tb_encoder_8_3_queue.sv
// Scoreboard bench for encoder_8_3_queue: one instance per priority order,
// both fed the same random and directed request streams.
module tb_encoder_8_3_queue;
    import encoder_8_3_queue_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       drv_e = 1'b0;
    logic [7:0] drv_in = 8'h00;
    logic       drv_rdy = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    encoder_8_3_queue_if if_hi ();
    encoder_8_3_queue_if if_lo ();

    assign if_hi.E = drv_e;  assign if_hi.In = drv_in;  assign if_hi.Ready = drv_rdy;
    assign if_lo.E = drv_e;  assign if_lo.In = drv_in;  assign if_lo.Ready = drv_rdy;

    encoder_8_3_queue #(.HIGH_FIRST(1'b1)) u_dut_hi (.clk(clk), .rst(rst), .bus(if_hi.master));
    encoder_8_3_queue #(.HIGH_FIRST(1'b0)) u_dut_lo (.clk(clk), .rst(rst), .bus(if_lo.master));

    // Reference model: k=0 highest-first, k=1 lowest-first.
    logic [7:0] m_pend [2];
    int         m_code [2];
    bit         m_vld  [2];
    bit         m_lost [2];
    int         expq   [2][$];

    // Behavioural model of the queue: pick winner from the pending set,
    // detect merges against the set minus the winner, then add new requests.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_pend[k] = 8'h00; m_code[k] = 0; m_vld[k] = 1'b0; m_lost[k] = 1'b0;
                expq[k].delete();
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                int  pick;
                bit  lost;
                pick = -1;
                lost = 1'b0;
                if (!m_vld[k] || drv_rdy) begin
                    for (int b = 0; b < 8; b++) begin
                        if (m_pend[k][b]) begin
                            if (k == 0) pick = b;
                            else if (pick < 0) pick = b;
                        end
                    end
                end
                for (int b = 0; b < 8; b++)
                    if (drv_e && drv_in[b] && m_pend[k][b] && b != pick) lost = 1'b1;
                if (pick >= 0) begin
                    m_pend[k][pick] = 1'b0;
                    m_code[k] = pick;
                    m_vld[k] = 1'b1;
                    expq[k].push_back(pick);
                end else if (m_vld[k] && drv_rdy) begin
                    m_vld[k] = 1'b0;
                end
                if (drv_e) m_pend[k] = m_pend[k] | drv_in;
                m_lost[k] = lost;
            end
        end
    end

    task automatic fail(input string name, input int got, input int exp);
        n_err++;
        $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    task automatic chk(input int k, input logic [7:0] pend, input logic lost,
                       input logic vld, input logic [2:0] out);
        string tag;
        tag = (k == 0) ? "hi" : "lo";
        n_vec++;
        if (pend !== m_pend[k]) fail({tag, " Pending"}, pend, m_pend[k]);
        n_vec++;
        if (lost !== m_lost[k]) fail({tag, " Lost"}, lost, m_lost[k]);
        n_vec++;
        if (vld !== m_vld[k]) fail({tag, " Valid"}, vld, m_vld[k]);
        if (vld === 1'b1) begin
            n_vec++;
            if (expq[k].size() == 0) begin
                fail({tag, " Out-unexpected"}, out, 0);
            end else begin
                if (out !== expq[k][0][2:0]) fail({tag, " Out"}, out, expq[k][0]);
                if (drv_rdy) void'(expq[k].pop_front());
            end
        end
    endtask

    // Monitor: compares away from the rising edge, pops a code per transfer.
    always @(negedge clk) begin
        if (!rst) begin
            chk(0, if_hi.Pending, if_hi.Lost, if_hi.Valid, if_hi.Out);
            chk(1, if_lo.Pending, if_lo.Lost, if_lo.Valid, if_lo.Out);
        end
    end

    task automatic cyc(input logic e, input logic [7:0] in, input logic rdy);
        @(posedge clk);
        #3;
        drv_e = e; drv_in = in; drv_rdy = rdy;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, rdy);
    endtask

    task automatic chk_reset(input string name, input logic [2:0] out, input logic vld,
                             input logic [7:0] pend, input logic lost);
        n_vec++;
        if ({out, vld, pend, lost} !== 13'd0) fail(name, {out, vld, pend, lost}, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;

        // Reset state right after release.
        chk_reset("hi reset state", if_hi.Out, if_hi.Valid, if_hi.Pending, if_hi.Lost);
        chk_reset("lo reset state", if_lo.Out, if_lo.Valid, if_lo.Pending, if_lo.Lost);

        // Single event.
        cyc(1'b1, 8'h20, 1'b1); idle(4, 1'b1);
        // Burst ordering.
        cyc(1'b1, 8'hA5, 1'b1); idle(6, 1'b1);
        // Backpressure.
        cyc(1'b1, 8'h03, 1'b0); idle(5, 1'b0); idle(4, 1'b1);
        // Lost and merge, then the E=0 variant.
        cyc(1'b1, 8'h01, 1'b0); idle(1, 1'b0);
        cyc(1'b1, 8'h10, 1'b0); cyc(1'b1, 8'h10, 1'b0); idle(2, 1'b0); idle(4, 1'b1);
        cyc(1'b1, 8'h01, 1'b0); idle(1, 1'b0);
        cyc(1'b1, 8'h10, 1'b0); cyc(1'b0, 8'h10, 1'b0); idle(2, 1'b0); idle(4, 1'b1);
        // Set-over-clear on the loading bit.
        cyc(1'b1, 8'h08, 1'b1); cyc(1'b1, 8'h08, 1'b1); idle(4, 1'b1);
        // Full burst.
        cyc(1'b1, 8'hFF, 1'b1); idle(10, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 600; i++)
            cyc($urandom_range(0, 3) != 0, 8'($urandom & $urandom), $urandom_range(0, 9) < 7);
        idle(12, 1'b1);

        // Asynchronous reset with a code presented and bits pending.
        cyc(1'b1, 8'h5A, 1'b0); cyc(1'b1, 8'h5A, 1'b0); idle(1, 1'b0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk_reset("hi async reset", if_hi.Out, if_hi.Valid, if_hi.Pending, if_hi.Lost);
        chk_reset("lo async reset", if_lo.Out, if_lo.Valid, if_lo.Pending, if_lo.Lost);
        @(posedge clk);
        #3 rst = 1'b0;
        cyc(1'b1, 8'h81, 1'b1); idle(6, 1'b1);

        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if (expq[k].size() != 0) fail("codes never emitted", expq[k].size(), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
